// File: rtl/revcomp_pkg.sv
// Shared constants and helpers for the reverse-complement sequencer.
// Base codes are plain ASCII; the state encoding is kept legacy-compatible.
package revcomp_pkg;

  localparam logic [7:0] BASE_A = 8'h41;
  localparam logic [7:0] BASE_C = 8'h43;
  localparam logic [7:0] BASE_G = 8'h47;
  localparam logic [7:0] BASE_T = 8'h54;
  localparam logic [7:0] BASE_N = 8'h4E;

  localparam logic [7:0] COMP_RESET_VALUE = 8'h02;

  localparam logic [1:0] ST_FILL  = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_SKIP  = 2'd2;

  function automatic logic is_acgt(input logic [7:0] base);
    case (base)
      BASE_A, BASE_C, BASE_G, BASE_T: is_acgt = 1'b1;
      default:                        is_acgt = 1'b0;
    endcase
  endfunction

  function automatic logic [7:0] complement_of(input logic [7:0] base);
    case (base)
      BASE_A:  complement_of = BASE_T;
      BASE_T:  complement_of = BASE_A;
      BASE_C:  complement_of = BASE_G;
      BASE_G:  complement_of = BASE_C;
      default: complement_of = BASE_N;
    endcase
  endfunction

endpackage

// File: rtl/complement_base.sv
// Registered single-base complementer: captures the complement of base_i on write.
// Reset is synchronous, active-high.
module complement_base
  import revcomp_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       write,
  input  logic [7:0] base_i,
  output logic [7:0] comp_o
);

  logic [7:0] comp_q;
  logic [7:0] comp_d;

  always_comb begin
    comp_d = comp_q;
    if (write) begin
      comp_d = complement_of(base_i);
    end else begin
      comp_d = comp_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      comp_q <= COMP_RESET_VALUE;
    end else begin
      comp_q <= comp_d;
    end
  end

  assign comp_o = comp_q;

endmodule

// File: rtl/revcomp_sequencer.sv
// Buffers a frame of ASCII bases in a LIFO and drains it as the reverse complement.
// Build option REVCOMP_STRICT_EN: non-ACGT bases are dropped and flagged instead of emitted as "N".
module revcomp_sequencer
  import revcomp_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [0:7] in_base,
  input  logic       in_last,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [0:7] out_base,
  output logic       out_last,
  output logic       truncated,
  output logic       bad_base,
  output logic       busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] CNT_ZERO    = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE     = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_FULL_M1 = CW'(DEPTH - 1);
  localparam logic [AW-1:0] IDX_ONE     = {{(AW-1){1'b0}}, 1'b1};

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic          skip_q, skip_d;
  logic          trunc_q, trunc_d;
  logic          bad_q, bad_d;
  logic          out_valid_q, out_valid_d;
  logic          out_last_q, out_last_d;
  logic          nflag_q, nflag_d;
  logic [8:0]    mem_q [DEPTH];

  logic [7:0]    base_s;
  logic          acgt_s;
  logic          accept_s;
  logic          store_s;
  logic          pop_s;
  logic [AW-1:0] top_idx_s;
  logic [8:0]    top_s;
  logic [7:0]    comp_s;

  assign base_s    = in_base;
  assign acgt_s    = is_acgt(base_s);
  assign in_ready  = reset & (state_q != ST_DRAIN);
  assign accept_s  = in_valid & in_ready;
  // Index wraps correctly when the LIFO is completely full.
  assign top_idx_s = count_q[AW-1:0] - IDX_ONE;
  assign top_s     = mem_q[top_idx_s];
  assign pop_s     = (state_q == ST_DRAIN) && (count_q != CNT_ZERO) && (!out_valid_q || out_ready);

`ifdef REVCOMP_STRICT_EN
  assign store_s = accept_s && (state_q == ST_FILL) && acgt_s;
`else
  assign store_s = accept_s && (state_q == ST_FILL);
`endif

  always_comb begin
    state_d = state_q;
    skip_d  = skip_q;
    trunc_d = trunc_q;
    case (state_q)
      ST_FILL: begin
        if (accept_s && in_last) begin
`ifdef REVCOMP_STRICT_EN
          // A dropped last base with nothing buffered ends an empty frame.
          if (store_s || (count_q != CNT_ZERO)) begin
            state_d = ST_DRAIN;
          end else begin
            state_d = ST_FILL;
          end
`else
          state_d = ST_DRAIN;
`endif
        end else if (store_s && (count_q == CNT_FULL_M1)) begin
          state_d = ST_DRAIN;
          trunc_d = 1'b1;
          skip_d  = 1'b1;
        end else begin
          state_d = ST_FILL;
        end
      end
      ST_DRAIN: begin
        if (pop_s && (count_q == CNT_ONE)) begin
          state_d = skip_q ? ST_SKIP : ST_FILL;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_SKIP: begin
        if (accept_s && in_last) begin
          state_d = ST_FILL;
          skip_d  = 1'b0;
        end else begin
          state_d = ST_SKIP;
        end
      end
      default: begin
        state_d = ST_FILL;
        skip_d  = 1'b0;
      end
    endcase
  end

  always_comb begin
    count_d     = count_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    nflag_d     = nflag_q;
    bad_d       = bad_q;
    if (store_s) begin
      count_d = count_q + CNT_ONE;
    end else if (pop_s) begin
      count_d = count_q - CNT_ONE;
    end else begin
      count_d = count_q;
    end
    if (pop_s) begin
      out_valid_d = 1'b1;
      out_last_d  = (count_q == CNT_ONE);
      nflag_d     = top_s[8];
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
`ifdef REVCOMP_STRICT_EN
    if (accept_s && !acgt_s) begin
      bad_d = 1'b1;
    end else begin
      bad_d = bad_q;
    end
`else
    bad_d = 1'b0;
`endif
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= ST_FILL;
      count_q     <= CNT_ZERO;
      skip_q      <= 1'b0;
      trunc_q     <= 1'b0;
      bad_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      nflag_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      skip_q      <= skip_d;
      trunc_q     <= trunc_d;
      bad_q       <= bad_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      nflag_q     <= nflag_d;
    end
  end

  // Storage needs no reset: the count alone decides what is valid.
  always_ff @(posedge clock) begin
    if (store_s) begin
      mem_q[count_q[AW-1:0]] <= {~acgt_s, base_s};
    end
  end

  complement_base u_comp (
    .clock  (clock),
    .reset  (~reset),
    .write  (pop_s),
    .base_i (top_s[7:0]),
    .comp_o (comp_s)
  );

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_base  = nflag_q ? BASE_N : comp_s;
  assign truncated = trunc_q;
  assign bad_base  = bad_q;
  assign busy      = (state_q != ST_FILL) || (count_q != CNT_ZERO) || out_valid_q;

endmodule

// File: tb/tb_revcomp_sequencer.sv
// Self-checking bench for revcomp_sequencer: frame-level reverse-complement model plus directed frames.
// Two instances: DEPTH=64 for normal frames, DEPTH=4 for truncation.
module tb_revcomp_sequencer;

`ifdef REVCOMP_STRICT_EN
  localparam bit STRICT = 1'b1;
`else
  localparam bit STRICT = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic       sel = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_base = 8'h00;
  logic       in_last = 1'b0;
  logic       out_ready = 1'b1;

  logic       b_in_ready, b_out_valid, b_out_last, b_trunc, b_bad, b_busy;
  logic [7:0] b_out_base;
  logic       s_in_ready, s_out_valid, s_out_last, s_trunc, s_bad, s_busy;
  logic [7:0] s_out_base;

  revcomp_sequencer #(.DEPTH(64)) u_big (
    .clock(clock), .reset(reset), .in_valid(in_valid & ~sel), .in_ready(b_in_ready),
    .in_base(in_base), .in_last(in_last), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_base(b_out_base), .out_last(b_out_last), .truncated(b_trunc), .bad_base(b_bad),
    .busy(b_busy)
  );

  revcomp_sequencer #(.DEPTH(4)) u_small (
    .clock(clock), .reset(reset), .in_valid(in_valid & sel), .in_ready(s_in_ready),
    .in_base(in_base), .in_last(in_last), .out_valid(s_out_valid), .out_ready(out_ready),
    .out_base(s_out_base), .out_last(s_out_last), .truncated(s_trunc), .bad_base(s_bad),
    .busy(s_busy)
  );

  logic       in_ready_m, out_valid_m, out_last_m, trunc_m, bad_m, busy_m;
  logic [7:0] out_base_m;
  assign in_ready_m  = sel ? s_in_ready  : b_in_ready;
  assign out_valid_m = sel ? s_out_valid : b_out_valid;
  assign out_last_m  = sel ? s_out_last  : b_out_last;
  assign out_base_m  = sel ? s_out_base  : b_out_base;
  assign trunc_m     = sel ? s_trunc     : b_trunc;
  assign bad_m       = sel ? s_bad       : b_bad;
  assign busy_m      = sel ? s_busy      : b_busy;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  logic [8:0] exp_q[$];
  logic [8:0] stored[$];
  logic [7:0] got_q[$];
  logic       gotl_q[$];
  int         acc_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: bound expired", name);
  endtask

  function automatic logic [7:0] rc(input logic [7:0] b, input logic nf);
    if (nf) return "N";
    case (b)
      "A": return "T";
      "T": return "A";
      "C": return "G";
      "G": return "C";
      default: return "N";
    endcase
  endfunction

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  // Model and compare process: runs on the falling edge, predicting the handshake at the next rising edge.
  initial begin : compare
    logic       have_prev;
    logic [7:0] prev_base;
    logic       prev_last;
    logic       m_skip;
    logic [1:0] m_trunc;
    logic [1:0] m_bad;
    logic [8:0] e;
    logic       ok;
    int         depth;
    have_prev = 1'b0; prev_base = 8'h00; prev_last = 1'b0;
    m_skip = 1'b0; m_trunc = 2'b00; m_bad = 2'b00;
    forever begin
      @(negedge clock);
      if (!reset) begin
        exp_q.delete();
        stored.delete();
        have_prev = 1'b0;
        m_skip = 1'b0;
        m_trunc = 2'b00;
        m_bad = 2'b00;
      end else begin
        check("truncated", trunc_m, m_trunc[sel]);
        check("bad_base", bad_m, m_bad[sel]);
        if (have_prev) begin
          check("hold_base", out_base_m, prev_base);
          check("hold_last", out_last_m, prev_last);
        end
        have_prev = out_valid_m && !out_ready;
        prev_base = out_base_m;
        prev_last = out_last_m;
        if (out_valid_m && out_ready) begin
          got_q.push_back(out_base_m);
          gotl_q.push_back(out_last_m);
          if (exp_q.size() == 0) begin
            fail_now("spurious_out");
          end else begin
            e = exp_q.pop_front();
            check("out_base", out_base_m, e[7:0]);
            check("out_last", out_last_m, e[8]);
          end
        end
        if (in_valid && in_ready_m) begin
          acc_q.push_back(cyc);
          depth = sel ? 4 : 64;
          ok = (in_base == "A") || (in_base == "C") || (in_base == "G") || (in_base == "T");
          if (STRICT && !ok) m_bad[sel] = 1'b1;
          if (m_skip) begin
            if (in_last) m_skip = 1'b0;
          end else begin
            if (!STRICT || ok) stored.push_back({~ok, in_base});
            if (in_last || stored.size() == depth) begin
              if (!in_last) begin
                m_trunc[sel] = 1'b1;
                m_skip = 1'b1;
              end
              for (int i = stored.size() - 1; i >= 0; i--) begin
                exp_q.push_back({i == 0, rc(stored[i][7:0], stored[i][8])});
              end
              stored.delete();
            end
          end
        end
      end
    end
  end

  task automatic send(input string s);
    int guard;
    @(posedge clock);
    #1;
    for (int i = 0; i < s.len(); i++) begin
      in_valid = 1'b1;
      in_base  = s[i];
      in_last  = (i == s.len() - 1);
      guard = 0;
      @(negedge clock);
      while (!in_ready_m && guard < 200) begin
        @(negedge clock);
        guard++;
      end
      if (guard >= 200) fail_now("send_timeout");
      @(posedge clock);
      #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    @(negedge clock);
    while ((busy_m || out_valid_m) && guard < 300) begin
      @(negedge clock);
      guard++;
    end
    if (guard >= 300) fail_now("idle_timeout");
  endtask

  task automatic check_seq(input string name, input int mark, input string eb, input string el);
    check({name, "_len"}, got_q.size() - mark, eb.len());
    for (int i = 0; i < eb.len() && (mark + i) < got_q.size(); i++) begin
      check({name, "_base"}, got_q[mark + i], eb[i]);
      check({name, "_last"}, gotl_q[mark + i], (el[i] == "1"));
    end
  endtask

  initial begin : stim
    int mark;
    int amark;
    int guard;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_in_ready", in_ready_m, 1'b0);
    check("rst_out_valid", out_valid_m, 1'b0);
    check("rst_out_last", out_last_m, 1'b0);
    check("rst_out_base", out_base_m, 8'h02);
    check("rst_truncated", trunc_m, 1'b0);
    check("rst_bad_base", bad_m, 1'b0);
    check("rst_busy", busy_m, 1'b0);
    @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    check("post_rst_in_ready", in_ready_m, 1'b1);

    // Plain frame with latency check.
    mark = got_q.size();
    send("ACGTT");
    @(negedge clock);
    check("lat_t1", out_valid_m, 1'b0);
    @(negedge clock);
    check("lat_t2", out_valid_m, 1'b1);
    wait_idle();
    check_seq("acgtt", mark, "AACGT", "00001");

    // Same frame with a stalling consumer.
    mark = got_q.size();
    fork
      send("ACGTT");
      begin
        @(posedge clock);
        #1;
        for (int k = 0; k < 40; k++) begin
          out_ready = (k % 4 == 0) || (k % 4 == 3);
          @(posedge clock);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    wait_idle();
    check_seq("stall", mark, "AACGT", "00001");

    // Truncation on the DEPTH=4 instance, then recovery.
    @(posedge clock);
    #1 sel = 1'b1;
    mark = got_q.size();
    send("GGGGGG");
    wait_idle();
    check_seq("trunc", mark, "CCCC", "0001");
    check("trunc_flag", trunc_m, 1'b1);
    mark = got_q.size();
    send("A");
    wait_idle();
    check_seq("after_skip", mark, "T", "1");
    check("trunc_sticky", trunc_m, 1'b1);

    // Non-ACGT handling.
    @(posedge clock);
    #1 sel = 1'b0;
    mark = got_q.size();
    send("AXG");
    wait_idle();
    if (STRICT) begin
      check_seq("axg", mark, "CT", "01");
      check("axg_bad", bad_m, 1'b1);
    end else begin
      check_seq("axg", mark, "CNT", "001");
      check("axg_bad", bad_m, 1'b0);
    end

    // Reset in the middle of a drain.
    mark = got_q.size();
    send("ACGT");
    guard = 0;
    while ((got_q.size() - mark) < 2 && guard < 50) begin
      @(negedge clock);
      guard++;
    end
    if (guard >= 50) fail_now("drain_timeout");
    @(posedge clock);
    #1 reset = 1'b0;
    @(posedge clock);
    @(negedge clock);
    check("mid_rst_out_valid", out_valid_m, 1'b0);
    check("mid_rst_out_base", out_base_m, 8'h02);
    check("mid_rst_in_ready", in_ready_m, 1'b0);
    @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    check("rel_in_ready", in_ready_m, 1'b1);
    check("rel_out_valid", out_valid_m, 1'b0);
    check("rel_out_base", out_base_m, 8'h02);
    check("rel_busy", busy_m, 1'b0);
    check("rel_bad", bad_m, 1'b0);
    repeat (10) @(negedge clock);
    check_seq("mid_rst", mark, "AC", "00");

    // Back-to-back frames.
    mark = got_q.size();
    amark = acc_q.size();
    send("A");
    send("CG");
    wait_idle();
    check_seq("b2b", mark, "TCG", "101");
    if (acc_q.size() >= amark + 2) begin
      check("b2b_gap", acc_q[amark + 1] - acc_q[amark], 2);
    end else begin
      fail_now("b2b_accepts");
    end

    check("leftover_expected", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bound expired");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/revcomp_sequencer.md
# revcomp_sequencer

- Converts a framed stream of ASCII DNA bases into its reverse complement, one frame at a time.
- Buffers each frame in a LIFO until `in_last` arrives, then drains the LIFO in reverse order through a `complement_base` instance, one base per write strobe.
- Sits between the base-ingest stream and downstream consumers; owns all sequencing of the complement unit.

## Interface
- `DEPTH`, 64: maximum bases per frame. Power of two, at least 2.
- `clock` in 1: single clock, all logic rising-edge.
- `reset` in 1: synchronous, active-low.
- `in_valid` in 1: input base present.
- `in_ready` out 1: input accepted when `in_valid & in_ready`.
- `in_base` in [0:7]: ASCII base.
- `in_last` in 1: final base of the frame.
- `out_valid` out 1: output base present.
- `out_ready` in 1: downstream accepts when `out_valid & out_ready`.
- `out_base` out [0:7]: complemented base.
- `out_last` out 1: final base of the reverse-complemented frame.
- `truncated` out 1: sticky; a frame exceeded `DEPTH`.
- `bad_base` out 1: sticky; a non-ACGT base was seen (strict builds only, otherwise tied 0).
- `busy` out 1: state is not FILL, or LIFO is non-empty, or `out_valid` is high.

## Operation
- States:
  - FILL: `in_ready`=1. Push on accept.
    - Accepted `in_last` → DRAIN.
    - Accept without `in_last` that makes count reach `DEPTH` → set `truncated` and a pending-skip flag, then → DRAIN.
  - DRAIN: `in_ready`=0. Pop top entry and pulse `complement_base.write` when the LIFO is non-empty and (`!out_valid` or `out_ready`).
    - Pop of the final entry → SKIP if pending-skip is set, else → FILL.
  - SKIP: `in_ready`=1. Discard accepted bases. Accepted `in_last` → FILL and clear pending-skip.
- LIFO count is `$clog2(DEPTH)+1` bits. Push and pop never occur in the same cycle (they belong to different states).
- A per-entry N flag is stored with each base. On pop it is registered alongside the write strobe. `out_base = nflag_q ? "N" : out_complement`.
- `out_last` registers (count==1) at pop time.
- `out_valid` sets the cycle after a pop. It clears on handshake unless a new pop occurs in the same cycle.
- `out_base` and `out_last` hold stable while `out_valid & !out_ready`.
- `truncated` and `bad_base` clear only on reset.

## Timing
- Reset (`reset`=0 at an edge): state FILL, LIFO empty, pending-skip 0.
- Output values during and after reset:
  - `in_ready`: 0 during reset, 1 in the first cycle after reset deasserts.
  - `out_valid`=0, `out_last`=0.
  - `out_base`=8'h02 (complement unit reset value, N flag 0).
  - `truncated`=0, `bad_base`=0, `busy`=0.
- Reset mid-frame or mid-drain discards all buffered data. No further output is produced.
- Last base accepted in cycle t: DRAIN from t+1, first pop at t+1, first `out_valid` at t+2.
- Throughput is 1 base/cycle with `out_ready` held high. A frame of N bases drains in N cycles.
- A new frame can be accepted in the cycle after the final pop. The pending last output may still be awaiting `out_ready` at that point.
- Frame length 1: output is that base's complement with `out_last`=1.

## Configuration
- `REVCOMP_STRICT_EN` defined:
  - A non-ACGT input is accepted, not stored, and sets `bad_base`.
  - If that base carries `in_last`: → DRAIN if the LIFO is non-empty, else stay in FILL and emit nothing.
- Undefined:
  - Non-ACGT bases are stored with N flag set and emitted as "N".
  - `bad_base` is tied 0.

## Structure
- Package `revcomp_pkg` holds:
  - Base constants "A", "C", "G", "T", "N".
  - State encoding FILL/DRAIN/SKIP.
  - Function `is_acgt`.
- Sub-module: existing `complement_base`. Drive its reset with `~reset` and its `write` with the pop strobe.
- LIFO storage stays inline.

## Test plan
- Frame "ACGTT" (last on T), `out_ready`=1 → out "AACGT", `out_last` only on final "T", first `out_valid` 2 cycles after last accept.
- Same frame with `out_ready` toggled 1,0,0,1… → identical sequence, with `out_base` held stable during stalls.
- `DEPTH`=4, frame of 6 "G" bases → 4 "C" out with `out_last` on the 4th, `truncated`=1, remaining 2 input bases discarded in SKIP, next frame "A" → "T".
- Frame "AXG" → strict build: out "CT", `bad_base`=1. Non-strict: out "CNT", `bad_base`=0.
- `reset`=0 asserted during DRAIN of "ACGT" after 2 outputs → `out_valid`=0, `out_base`=8'h02, `in_ready`=1 in the first cycle after reset deasserts, no stale bases emitted.
- Back-to-back frames "A" and "CG" → out "T"(last), "CG"(last on G), with no gap beyond the DRAIN entry.
